instruction_memory: RTL and testbench

Parametrised, loadable instruction memory that replaces the fixed case-table ROM in the fetch stage. Holds the program in a synchronous RAM, fills it through a valid/ready loader port, and delivers registered instructions to the pipeline with stall and flush control. Unloaded or out-of-image addresses, and every fetch during a load, return the NOP word, so the pipeline always sees a defined instruction.

---
 rtl/instruction_memory_pkg.sv | 25 ++
 rtl/instruction_memory_if.sv | 40 ++++
 rtl/instruction_memory_ram_array.sv | 37 +++
 rtl/instruction_memory.sv | 136 +++++++++++++
 tb/tb_instruction_memory.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_memory_pkg.sv
// Shared definitions for the loadable instruction memory: opcode encodings,
// loader FSM state encoding and default geometry.
package instruction_memory_pkg;

  localparam int IM_ADDR_WIDTH    = 10;
  localparam int IM_OPCODE_WIDTH  = 6;
  localparam int IM_OPERAND_WIDTH = 10;

  // Opcode encodings shared with the decoder.
  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_LDA  = 6'h01;
  localparam logic [5:0] OP_STA  = 6'h02;
  localparam logic [5:0] OP_ADDA = 6'h03;
  localparam logic [5:0] OP_ANDA = 6'h04;
  localparam logic [5:0] OP_JMP  = 6'h05;
  localparam logic [5:0] OP_JZ   = 6'h06;
  localparam logic [5:0] OP_HALT = 6'h3F;

  typedef enum logic [1:0] {
    IM_IDLE   = 2'd0,
    IM_LOAD   = 2'd1,
    IM_COMMIT = 2'd2
  } im_state_e;

endpackage

// File: rtl/instruction_memory_if.sv
// Fetch and loader signals of the instruction memory; the memory is the
// slave, the pipeline/loader side is the master.
interface instruction_memory_if #(
  parameter int ADDR_WIDTH    = 10,
  parameter int OPCODE_WIDTH  = 6,
  parameter int OPERAND_WIDTH = 10
);
  localparam int INSTR_WIDTH = OPCODE_WIDTH + OPERAND_WIDTH;

  logic                   fetch_enable_i;
  logic                   flush_i;
  logic [ADDR_WIDTH-1:0]  address_i;
  logic [INSTR_WIDTH-1:0] instruction_o;

  logic                   load_start_i;
  logic [ADDR_WIDTH:0]    load_length_i;
  logic                   load_valid_i;
  logic [INSTR_WIDTH-1:0] load_data_i;
  logic                   load_ready_o;
  logic                   load_abort_i;
  logic                   busy_o;
  logic                   load_done_o;
  logic                   load_error_o;
  logic [ADDR_WIDTH:0]    program_size_o;

  modport slave (
    input  fetch_enable_i, flush_i, address_i,
    input  load_start_i, load_length_i, load_valid_i, load_data_i, load_abort_i,
    output instruction_o, load_ready_o, busy_o, load_done_o, load_error_o,
    output program_size_o
  );

  modport master (
    output fetch_enable_i, flush_i, address_i,
    output load_start_i, load_length_i, load_valid_i, load_data_i, load_abort_i,
    input  instruction_o, load_ready_o, busy_o, load_done_o, load_error_o,
    input  program_size_o
  );

endinterface

// File: rtl/instruction_memory_ram_array.sv
// Simple dual-port program RAM: one write port, one synchronous read port
// whose output register holds when the read enable is low.
module instruction_ram_array #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // NOTE: the array and its read register have no reset; stale contents are
  // masked by the top level until an image is committed, and a reset port
  // would keep the array from mapping onto block RAM.
  // NOTE: non-blocking assignments so the read sees the pre-edge array
  // contents and statement order inside the block does not matter.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instruction_memory.sv
// Loadable instruction memory: valid/ready image loader with IDLE/LOAD/COMMIT
// FSM, and a registered fetch port with stall, flush and NOP masking.
module instruction_memory
  import instruction_memory_pkg::*;
#(
  parameter int ADDR_WIDTH    = IM_ADDR_WIDTH,
  parameter int OPCODE_WIDTH  = IM_OPCODE_WIDTH,
  parameter int OPERAND_WIDTH = IM_OPERAND_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  instruction_memory_if.slave bus
);

  localparam int INSTR_WIDTH = OPCODE_WIDTH + OPERAND_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [INSTR_WIDTH-1:0] NOP_WORD =
    {OPCODE_WIDTH'(OP_NOP), {OPERAND_WIDTH{1'b0}}};

  im_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] last_idx_q, last_idx_d;
  logic [ADDR_WIDTH:0]   length_q, length_d;
  logic [ADDR_WIDTH:0]   prog_size_q, prog_size_d;
  logic                  load_error_q, load_error_d;
  logic                  fetch_nop_q, fetch_nop_d;

  logic                   length_ok;
  logic                   ram_we;
  logic                   ram_re;
  logic [INSTR_WIDTH-1:0] ram_rdata;

  assign length_ok = (bus.load_length_i != '0) && (bus.load_length_i <= DEPTH);

  always_comb begin
    // NOTE: every target of this block gets a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    last_idx_d   = last_idx_q;
    length_d     = length_q;
    prog_size_d  = prog_size_q;
    load_error_d = 1'b0;
    ram_we       = 1'b0;

    unique case (state_q)
      IM_IDLE: begin
        if (bus.load_start_i) begin
          if (length_ok) begin
            length_d    = bus.load_length_i;
            last_idx_d  = ADDR_WIDTH'(bus.load_length_i - 1'b1);
            wr_ptr_d    = '0;
            prog_size_d = '0;
            state_d     = IM_LOAD;
          end else begin
            load_error_d = 1'b1;
          end
        end
      end
      IM_LOAD: begin
        // Abort wins over a same-cycle beat; that word is never written.
        if (bus.load_abort_i) begin
          prog_size_d = '0;
          state_d     = IM_IDLE;
        end else if (bus.load_valid_i) begin
          ram_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (wr_ptr_q == last_idx_q) begin
            state_d = IM_COMMIT;
          end
        end
      end
      IM_COMMIT: begin
        prog_size_d = length_q;
        state_d     = IM_IDLE;
      end
      default: begin
        state_d = IM_IDLE;
      end
    endcase
  end

  // The RAM read register doubles as the fetch register; fetch_nop_q records
  // whether the word presented this cycle must be replaced by NOP.
  always_comb begin
    fetch_nop_d = fetch_nop_q;
    ram_re      = 1'b0;
    if (bus.flush_i) begin
      fetch_nop_d = 1'b1;
    end else if (bus.fetch_enable_i) begin
      fetch_nop_d = (state_q != IM_IDLE) || ({1'b0, bus.address_i} >= prog_size_q);
      ram_re      = ~fetch_nop_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IM_IDLE;
      wr_ptr_q     <= '0;
      last_idx_q   <= '0;
      length_q     <= '0;
      prog_size_q  <= '0;
      load_error_q <= 1'b0;
      fetch_nop_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      last_idx_q   <= last_idx_d;
      length_q     <= length_d;
      prog_size_q  <= prog_size_d;
      load_error_q <= load_error_d;
      fetch_nop_q  <= fetch_nop_d;
    end
  end

  instruction_ram_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (INSTR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.load_data_i),
    .re_i    (ram_re),
    .raddr_i (bus.address_i),
    .rdata_o (ram_rdata)
  );

  assign bus.instruction_o  = fetch_nop_q ? NOP_WORD : ram_rdata;
  assign bus.load_ready_o   = (state_q == IM_LOAD);
  assign bus.busy_o         = (state_q == IM_LOAD);
  assign bus.load_done_o    = (state_q == IM_COMMIT);
  assign bus.load_error_o   = load_error_q;
  assign bus.program_size_o = prog_size_q;

endmodule

// File: tb/tb_instruction_memory.sv
// Scoreboard bench for instruction_memory: the driver pushes expected
// post-edge values, a monitor pops and compares them after each edge.
module tb_instruction_memory;
  import instruction_memory_pkg::*;

  localparam int AW    = 10;
  localparam int OPW   = 6;
  localparam int ODW   = 10;
  localparam int IW    = OPW + ODW;
  localparam int LW    = AW + 1;
  localparam int DEPTH = 1 << AW;
  localparam logic [IW-1:0] NOP = {OP_NOP, 10'd0};

  typedef enum {K_INSTR, K_SIZE, K_BUSY, K_READY, K_DONE, K_ERR} kind_e;
  typedef struct {
    kind_e       kind;
    logic [31:0] value;
  } exp_t;

  logic clk;
  logic rst_n;

  instruction_memory_if #(.ADDR_WIDTH(AW), .OPCODE_WIDTH(OPW), .OPERAND_WIDTH(ODW)) bus ();

  instruction_memory #(.ADDR_WIDTH(AW), .OPCODE_WIDTH(OPW), .OPERAND_WIDTH(ODW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  exp_t exp_q[$];

  // Reference model: committed image, its size, whether the loader is idle
  // at the coming edge, and the instruction the pipeline should be holding.
  logic [IW-1:0] model_mem [DEPTH];
  logic [IW-1:0] stage     [DEPTH];
  int            model_size;
  bit            model_idle;
  logic [IW-1:0] model_instr;
  logic [IW-1:0] load_words[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic push(input kind_e k, input logic [31:0] v);
    exp_t e;
    e.kind  = k;
    e.value = v;
    exp_q.push_back(e);
  endtask

  // Monitor: items queued before an edge describe the outputs after it.
  initial begin
    int n;
    exp_t e;
    logic [31:0] act;
    forever begin
      @(posedge clk);
      n = exp_q.size();
      @(negedge clk);
      for (int i = 0; i < n; i++) begin
        e = exp_q.pop_front();
        case (e.kind)
          K_INSTR: act = 32'(bus.instruction_o);
          K_SIZE:  act = 32'(bus.program_size_o);
          K_BUSY:  act = 32'(bus.busy_o);
          K_READY: act = 32'(bus.load_ready_o);
          K_DONE:  act = 32'(bus.load_done_o);
          default: act = 32'(bus.load_error_o);
        endcase
        check(e.kind.name(), act, e.value);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end

  function automatic logic [IW-1:0] mk(input logic [5:0] op, input int operand);
    return {op, ODW'(operand)};
  endfunction

  function automatic logic [IW-1:0] load_word(input int i);
    if (i < load_words.size()) return load_words[i];
    return IW'($urandom);
  endfunction

  // Drives one edge with the current inputs; expected fetch result is pushed.
  task automatic cycle();
    logic [IW-1:0] e;
    if (bus.flush_i) e = NOP;
    else if (!bus.fetch_enable_i) e = model_instr;
    else if (!model_idle || int'(bus.address_i) >= model_size) e = NOP;
    else e = model_mem[bus.address_i];
    model_instr = e;
    push(K_INSTR, 32'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic set_fetch(input int addr, input bit en, input bit fl);
    bus.address_i      = AW'(addr);
    bus.fetch_enable_i = en;
    bus.flush_i        = fl;
  endtask

  task automatic rand_fetch();
    int hi = (model_size > 0) ? model_size : 4;
    if ($urandom_range(0, 3) == 0) bus.address_i = AW'($urandom);
    else bus.address_i = AW'($urandom_range(0, hi));
    bus.fetch_enable_i = ($urandom_range(0, 3) != 0);
    bus.flush_i        = ($urandom_range(0, 7) == 0);
  endtask

  task automatic clear_inputs();
    set_fetch(0, 1'b0, 1'b0);
    bus.load_start_i  = 1'b0;
    bus.load_length_i = '0;
    bus.load_valid_i  = 1'b0;
    bus.load_data_i   = '0;
    bus.load_abort_i  = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    clear_inputs();
    #2;
    check("rst_instr", 32'(bus.instruction_o), 32'(NOP));
    check("rst_size", 32'(bus.program_size_o), 0);
    check("rst_busy", 32'(bus.busy_o), 0);
    check("rst_ready", 32'(bus.load_ready_o), 0);
    check("rst_done", 32'(bus.load_done_o), 0);
    check("rst_err", 32'(bus.load_error_o), 0);
    model_size  = 0;
    model_idle  = 1'b1;
    model_instr = NOP;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // mode: 0 valid always high, 1 valid toggles from 1, 2 random valid.
  // kill_after >= 0 aborts (or resets) once that many words are accepted.
  task automatic do_load(input int len, input int kill_after, input bit kill_reset, input int mode);
    int acc  = 0;
    int beat = 0;
    bit ok   = (len >= 1 && len <= DEPTH);
    bit valid;
    bit last;
    logic [IW-1:0] w;

    rand_fetch();
    bus.load_start_i  = 1'b1;
    bus.load_length_i = LW'(len);
    model_idle = 1'b1;
    push(K_ERR, 32'(!ok));
    push(K_BUSY, 32'(ok));
    push(K_READY, 32'(ok));
    push(K_DONE, 0);
    push(K_SIZE, ok ? 0 : 32'(model_size));
    cycle();
    bus.load_start_i = 1'b0;
    if (!ok) begin
      rand_fetch();
      push(K_ERR, 0);
      push(K_BUSY, 0);
      push(K_SIZE, 32'(model_size));
      cycle();
      return;
    end

    model_idle = 1'b0;
    while (acc < len) begin
      if (acc == kill_after) begin
        if (kill_reset) begin
          apply_reset();
        end else begin
          rand_fetch();
          bus.load_abort_i = 1'b1;
          bus.load_valid_i = 1'($urandom_range(0, 1));
          bus.load_data_i  = IW'($urandom);
          push(K_BUSY, 0);
          push(K_READY, 0);
          push(K_DONE, 0);
          push(K_SIZE, 0);
          cycle();
          bus.load_abort_i = 1'b0;
          bus.load_valid_i = 1'b0;
          model_idle = 1'b1;
          model_size = 0;
        end
        return;
      end
      case (mode)
        0:       valid = 1'b1;
        1:       valid = (beat % 2 == 0);
        default: valid = ($urandom_range(0, 2) != 0);
      endcase
      w    = load_word(acc);
      last = valid && (acc == len - 1);
      rand_fetch();
      bus.load_valid_i  = valid;
      bus.load_data_i   = valid ? w : IW'($urandom);
      bus.load_start_i  = ($urandom_range(0, 7) == 0);
      bus.load_length_i = LW'($urandom);
      push(K_BUSY, 32'(!last));
      push(K_READY, 32'(!last));
      push(K_DONE, 32'(last));
      push(K_ERR, 0);
      push(K_SIZE, 0);
      cycle();
      if (valid) begin
        stage[acc] = w;
        acc++;
      end
      beat++;
    end

    bus.load_valid_i = 1'b0;
    bus.load_start_i = 1'b0;
    rand_fetch();
    push(K_DONE, 0);
    push(K_BUSY, 0);
    push(K_READY, 0);
    push(K_SIZE, 32'(len));
    cycle();
    for (int i = 0; i < len; i++) model_mem[i] = stage[i];
    model_size = len;
    model_idle = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    apply_reset();

    // No image yet: every fetch returns NOP.
    for (int a = 0; a < 6; a++) begin
      set_fetch(a, 1'b1, 1'b0);
      push(K_SIZE, 0);
      cycle();
    end

    // Three-word image, valid held high, then sequential fetch 0..3.
    load_words = '{mk(OP_STA, 231), mk(OP_ANDA, 45), mk(OP_JMP, 0)};
    do_load(3, -1, 1'b0, 0);
    for (int a = 0; a < 4; a++) begin
      set_fetch(a, 1'b1, 1'b0);
      cycle();
    end

    // Stall holds {ANDA,45}; flush wins over fetch enable.
    set_fetch(1, 1'b1, 1'b0);
    cycle();
    for (int i = 0; i < 3; i++) begin
      set_fetch($urandom_range(0, 2), 1'b0, 1'b0);
      cycle();
    end
    set_fetch(1, 1'b1, 1'b1);
    cycle();
    set_fetch(2, 1'b1, 1'b0);
    cycle();

    // Toggling valid: 1,0,1,0,1 for a three-word image.
    load_words = '{mk(OP_LDA, 7), mk(OP_ADDA, 500), mk(OP_HALT, 1023)};
    do_load(3, -1, 1'b0, 1);
    for (int a = 0; a < 4; a++) begin
      set_fetch(a, 1'b1, 1'b0);
      cycle();
    end
    load_words.delete();

    // Illegal lengths leave image and size intact.
    do_load(0, -1, 1'b0, 0);
    do_load(DEPTH + 1, -1, 1'b0, 0);
    do_load($urandom_range(DEPTH + 2, 2 * DEPTH - 1), -1, 1'b0, 0);
    for (int a = 0; a < 3; a++) begin
      set_fetch(a, 1'b1, 1'b0);
      cycle();
    end

    // Abort after 2 of 4 words, then reset after 2 of 4 words.
    do_load(4, 2, 1'b0, 0);
    set_fetch(0, 1'b1, 1'b0);
    push(K_SIZE, 0);
    cycle();
    do_load(2, -1, 1'b0, 0);
    do_load(4, 2, 1'b1, 0);
    set_fetch(0, 1'b1, 1'b0);
    push(K_SIZE, 0);
    cycle();

    // Full-depth image: write pointer wraps on the final beat.
    do_load(DEPTH, -1, 1'b0, 0);
    foreach (stage[i]) if (i == 0 || i == DEPTH - 1 || i == DEPTH / 2) begin
      set_fetch(i, 1'b1, 1'b0);
      cycle();
    end

    // Randomised loads, aborts and fetch traffic.
    for (int it = 0; it < 12; it++) begin
      int len = $urandom_range(1, 24);
      int kill = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      do_load(len, kill, 1'b0, 2);
      for (int c = 0; c < 16; c++) begin
        rand_fetch();
        cycle();
      end
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
